// File: rtl/axi_req_arbiter_if.sv
// Bundle of the requester command/response ports and the AXI4 master port used by
// axi_req_arbiter. The master modport is the arbiter's view; slave is the environment's.
interface axi_req_arbiter_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 1
);
  logic [1:0]          RQ_VALID;
  logic [1:0]          RQ_WRITE;
  logic [2*ADDR_W-1:0] RQ_ADDR;
  logic [2*DATA_W-1:0] RQ_WDATA;
  logic [1:0]          RQ_READY;
  logic [1:0]          RSP_VALID;
  logic [DATA_W-1:0]   RSP_RDATA;
  logic                RSP_ERR;

  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [ID_W-1:0]     M_AXI_AWID;
  logic [7:0]          M_AXI_AWLEN;
  logic [2:0]          M_AXI_AWSIZE;
  logic [1:0]          M_AXI_AWBURST;
  logic [2:0]          M_AXI_AWPROT;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WLAST;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [ID_W-1:0]     M_AXI_BID;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic [ID_W-1:0]     M_AXI_ARID;
  logic [7:0]          M_AXI_ARLEN;
  logic [2:0]          M_AXI_ARSIZE;
  logic [1:0]          M_AXI_ARBURST;
  logic [2:0]          M_AXI_ARPROT;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [ID_W-1:0]     M_AXI_RID;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RLAST;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  modport master (
    input  RQ_VALID, RQ_WRITE, RQ_ADDR, RQ_WDATA,
    output RQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    output M_AXI_AWADDR, M_AXI_AWID, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWPROT,
    output M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARPROT,
    output M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RID, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    output RQ_VALID, RQ_WRITE, RQ_ADDR, RQ_WDATA,
    input  RQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    input  M_AXI_AWADDR, M_AXI_AWID, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWPROT,
    input  M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARPROT,
    input  M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RID, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi_req_arbiter.sv
// Two-port round-robin arbiter in front of one AXI4 slave; each accepted command becomes
// a single-beat write or read, with at most one transaction outstanding.
module axi_req_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 1
) (
  input logic               ACLK,
  input logic               ARESETn,
  axi_req_arbiter_if.master bus
);

  localparam int unsigned StrbW = DATA_W / 8;

  typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdResp} state_e;

  state_e              state_q;
  logic                ptr_q;
  logic                id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                arvalid_q;
  logic [1:0]          rsp_valid_q;
  logic                rsp_err_q;

  logic                any_valid;
  logic                winner;
  logic [ID_W-1:0]     id_ext;
  logic                aw_left;
  logic                w_left;

  always_comb begin
    any_valid = |bus.RQ_VALID;
    // On a tie the requester that did not win last time goes next.
    winner    = (bus.RQ_VALID == 2'b11) ? ~ptr_q : bus.RQ_VALID[1];
    id_ext    = ID_W'(id_q);
    aw_left   = awvalid_q & ~bus.M_AXI_AWREADY;
    w_left    = wvalid_q & ~bus.M_AXI_WREADY;
  end

  assign bus.RQ_READY = (state_q == StIdle && any_valid) ? (winner ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b1;
      id_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 2'b00;
      case (state_q)
        StIdle: begin
          if (any_valid) begin
            addr_q  <= winner ? bus.RQ_ADDR[2*ADDR_W-1:ADDR_W] : bus.RQ_ADDR[ADDR_W-1:0];
            wdata_q <= winner ? bus.RQ_WDATA[2*DATA_W-1:DATA_W] : bus.RQ_WDATA[DATA_W-1:0];
            id_q    <= winner;
            ptr_q   <= winner;
            if (bus.RQ_WRITE[winner]) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= StWrReq;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StRdReq;
            end
          end
        end
        StWrReq: begin
          // AW and W retire independently; move on once neither is still pending.
          awvalid_q <= aw_left;
          wvalid_q  <= w_left;
          if (!aw_left && !w_left) state_q <= StWrResp;
        end
        StWrResp: begin
          if (bus.M_AXI_BVALID) begin
            state_q           <= StIdle;
            rsp_valid_q[id_q] <= 1'b1;
            rsp_err_q         <= (bus.M_AXI_BRESP != 2'b00) || (bus.M_AXI_BID != id_ext);
          end
        end
        StRdReq: begin
          if (bus.M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            state_q   <= StRdResp;
          end
        end
        StRdResp: begin
          if (bus.M_AXI_RVALID) begin
            state_q           <= StIdle;
            rdata_q           <= bus.M_AXI_RDATA;
            rsp_valid_q[id_q] <= 1'b1;
            rsp_err_q         <= (bus.M_AXI_RRESP != 2'b00) || !bus.M_AXI_RLAST ||
                                 (bus.M_AXI_RID != id_ext);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.M_AXI_AWADDR  = addr_q;
  assign bus.M_AXI_AWID    = id_ext;
  assign bus.M_AXI_AWLEN   = 8'd0;
  assign bus.M_AXI_AWSIZE  = 3'($clog2(StrbW));
  assign bus.M_AXI_AWBURST = 2'b01;
  assign bus.M_AXI_AWPROT  = 3'b000;
  assign bus.M_AXI_AWVALID = awvalid_q;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = '1;
  assign bus.M_AXI_WLAST   = 1'b1;
  assign bus.M_AXI_WVALID  = wvalid_q;
  assign bus.M_AXI_BREADY  = (state_q == StWrResp);
  assign bus.M_AXI_ARADDR  = addr_q;
  assign bus.M_AXI_ARID    = id_ext;
  assign bus.M_AXI_ARLEN   = 8'd0;
  assign bus.M_AXI_ARSIZE  = 3'($clog2(StrbW));
  assign bus.M_AXI_ARBURST = 2'b01;
  assign bus.M_AXI_ARPROT  = 3'b000;
  assign bus.M_AXI_ARVALID = arvalid_q;
  assign bus.M_AXI_RREADY  = (state_q == StRdResp);
  assign bus.RSP_VALID     = rsp_valid_q;
  assign bus.RSP_RDATA     = rdata_q;
  assign bus.RSP_ERR       = rsp_err_q;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed bench for axi_req_arbiter: a behavioural AXI slave with delay/error knobs,
// and a scoreboard of expected responses filled at command accept.
module tb_axi_req_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;

  logic ACLK = 1'b0;
  logic ARESETn;
  always #5 ACLK = ~ACLK;

  axi_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(1)) bus ();
  axi_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(1)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus)
  );

  typedef struct {
    bit          owner;
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    bit          err;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  int grant_log[$];
  logic [31:0] last_rd = '0;
  logic [31:0] ref_mem[64];

  // Slave knobs
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_k = 2'b00;
  bit rlast_k = 1'b1, rid_flip = 1'b0, bid_flip = 1'b0;

  // Monitor observations
  int aw_hi = 0, w_hi = 0, rdy0_hi = 0;
  bit mon_aw = 0, mon_w = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // ---------------- AXI slave model ----------------
  logic [31:0] smem[64];
  bit s_aw, s_w, s_ar;
  logic [5:0] s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  logic s_awid, s_arid;
  bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
  int aw_cnt, w_cnt, ar_cnt, r_cnt;

  initial begin
    bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0;
    bus.M_AXI_BID = 0; bus.M_AXI_BRESP = 0; bus.M_AXI_ARREADY = 0;
    bus.M_AXI_RVALID = 0; bus.M_AXI_RDATA = 0; bus.M_AXI_RID = 0;
    bus.M_AXI_RRESP = 0; bus.M_AXI_RLAST = 0;
    s_aw = 0; s_w = 0; s_ar = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
    for (int i = 0; i < 64; i++) smem[i] = 32'hA5A5_0000 + i;
    forever begin
      @(negedge ACLK);
      aw_hs = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
      w_hs  = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
      b_hs  = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
      ar_hs = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
      r_hs  = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
      if (aw_hs) begin s_aw = 1; s_awaddr = bus.M_AXI_AWADDR; s_awid = bus.M_AXI_AWID; end
      if (w_hs) begin s_w = 1; s_wdata = bus.M_AXI_WDATA; end
      if (ar_hs) begin
        s_ar = 1; s_araddr = bus.M_AXI_ARADDR; s_arid = bus.M_AXI_ARID; r_cnt = 0;
      end
      @(posedge ACLK);
      #1;
      if (!ARESETn) begin
        bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0;
        bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0;
        s_aw = 0; s_w = 0; s_ar = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
        continue;
      end
      if (bus.M_AXI_AWVALID && !s_aw) begin
        if (aw_cnt >= aw_dly) bus.M_AXI_AWREADY = 1;
        else begin bus.M_AXI_AWREADY = 0; aw_cnt++; end
      end else begin bus.M_AXI_AWREADY = 0; aw_cnt = 0; end
      if (bus.M_AXI_WVALID && !s_w) begin
        if (w_cnt >= w_dly) bus.M_AXI_WREADY = 1;
        else begin bus.M_AXI_WREADY = 0; w_cnt++; end
      end else begin bus.M_AXI_WREADY = 0; w_cnt = 0; end
      if (bus.M_AXI_ARVALID && !s_ar) begin
        if (ar_cnt >= ar_dly) bus.M_AXI_ARREADY = 1;
        else begin bus.M_AXI_ARREADY = 0; ar_cnt++; end
      end else begin bus.M_AXI_ARREADY = 0; ar_cnt = 0; end
      if (b_hs) bus.M_AXI_BVALID = 0;
      if (!bus.M_AXI_BVALID && s_aw && s_w) begin
        smem[s_awaddr] = s_wdata;
        bus.M_AXI_BVALID = 1;
        bus.M_AXI_BID = s_awid ^ bid_flip;
        bus.M_AXI_BRESP = bresp_k;
        s_aw = 0; s_w = 0;
      end
      if (r_hs) bus.M_AXI_RVALID = 0;
      if (s_ar && !bus.M_AXI_RVALID) begin
        if (r_cnt >= r_dly) begin
          bus.M_AXI_RVALID = 1;
          bus.M_AXI_RDATA = smem[s_araddr];
          bus.M_AXI_RID = s_arid ^ rid_flip;
          bus.M_AXI_RRESP = 2'b00;
          bus.M_AXI_RLAST = rlast_k;
          s_ar = 0;
        end else r_cnt++;
      end
    end
  end

  // ---------------- Monitor / scoreboard ----------------
  exp_t e;
  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        mon_aw = 0; mon_w = 0;
        continue;
      end
      if (bus.RQ_VALID != 2'b00) chk("rq_ready_onehot", 64'($onehot0(bus.RQ_READY)), 64'd1);
      if (bus.RQ_READY[0]) rdy0_hi++;
      for (int i = 0; i < 2; i++) begin
        if (bus.RQ_VALID[i] && bus.RQ_READY[i]) begin
          e.owner = i[0];
          e.wr    = bus.RQ_WRITE[i];
          e.addr  = bus.RQ_ADDR[i*AW +: AW];
          if (e.wr) begin
            e.data = bus.RQ_WDATA[i*DW +: DW];
            ref_mem[e.addr] = e.data;
            e.err = (bresp_k != 2'b00) || bid_flip;
          end else begin
            e.data = ref_mem[e.addr];
            e.err = !rlast_k || rid_flip;
          end
          sb.push_back(e);
          grant_log.push_back(i);
        end
      end
      if (bus.M_AXI_AWVALID || bus.M_AXI_WVALID || bus.M_AXI_BVALID ||
          bus.M_AXI_ARVALID || bus.M_AXI_RVALID)
        chk("no_overlap", 64'((bus.M_AXI_AWVALID | bus.M_AXI_WVALID | bus.M_AXI_BVALID) &&
                             (bus.M_AXI_ARVALID | bus.M_AXI_RVALID)), 64'd0);
      if (sb.size() > 0) begin
        if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
          chk("awaddr", bus.M_AXI_AWADDR, sb[0].addr);
          chk("awid", bus.M_AXI_AWID, sb[0].owner);
          chk("aw_consts", {bus.M_AXI_AWLEN, bus.M_AXI_AWSIZE, bus.M_AXI_AWBURST,
                            bus.M_AXI_AWPROT}, {8'd0, 3'd2, 2'b01, 3'd0});
        end
        if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
          chk("wdata", bus.M_AXI_WDATA, sb[0].data);
          chk("wstrb_wlast", {bus.M_AXI_WSTRB, bus.M_AXI_WLAST}, {4'hF, 1'b1});
        end
        if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
          chk("araddr", bus.M_AXI_ARADDR, sb[0].addr);
          chk("arid", bus.M_AXI_ARID, sb[0].owner);
        end
      end
      if (bus.M_AXI_BREADY) chk("bready_after_both", {mon_aw, mon_w}, 2'b11);
      if (bus.M_AXI_AWVALID) aw_hi++;
      if (bus.M_AXI_WVALID) w_hi++;
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) mon_aw = 1;
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) mon_w = 1;
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin mon_aw = 0; mon_w = 0; end
      if (bus.RSP_VALID != 2'b00) begin
        if (sb.size() == 0) chk("rsp_unexpected", bus.RSP_VALID, 2'b00);
        else begin
          e = sb.pop_front();
          if (!e.wr) last_rd = e.data;
          chk("rsp_owner", bus.RSP_VALID, e.owner ? 2'b10 : 2'b01);
          chk("rsp_rdata", bus.RSP_RDATA, last_rd);
          chk("rsp_err", bus.RSP_ERR, e.err);
        end
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic drive(input int r, input bit wr, input logic [5:0] a);
    bus.RQ_WRITE[r] = wr;
    bus.RQ_ADDR[r*AW +: AW] = a;
    bus.RQ_WDATA[r*DW +: DW] = 32'h1000_0000 * (r + 1) + 32'(a);
  endtask

  task automatic issue(input int r, input bit wr, input logic [5:0] a, input logic [31:0] d);
    bit ok = 0;
    @(posedge ACLK);
    #1;
    bus.RQ_VALID[r] = 1'b1;
    bus.RQ_WRITE[r] = wr;
    bus.RQ_ADDR[r*AW +: AW] = a;
    bus.RQ_WDATA[r*DW +: DW] = d;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge ACLK);
      ok = bus.RQ_READY[r];
    end
    if (!ok) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge ACLK);
    #1;
    bus.RQ_VALID[r] = 1'b0;
  endtask

  task automatic wait_done();
    int c = 0;
    while (sb.size() != 0 && c < 200) begin
      @(posedge ACLK);
      c++;
    end
    if (sb.size() != 0) chk("rsp_timeout", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge ACLK);
  endtask

  task automatic run_both(input int n, input bit wr0, input bit wr1,
                          input logic [5:0] b0, input logic [5:0] b1);
    int k0 = 0, k1 = 0;
    logic [1:0] acc;
    @(posedge ACLK);
    #1;
    drive(0, wr0, b0);
    drive(1, wr1, b1);
    bus.RQ_VALID = 2'b11;
    for (int c = 0; c < 400 && (k0 < n || k1 < n); c++) begin
      @(negedge ACLK);
      acc = bus.RQ_VALID & bus.RQ_READY;
      @(posedge ACLK);
      #1;
      if (acc[0]) begin
        k0++;
        if (k0 < n) drive(0, wr0, b0 + 6'(2 * k0)); else bus.RQ_VALID[0] = 1'b0;
      end
      if (acc[1]) begin
        k1++;
        if (k1 < n) drive(1, wr1, b1 + 6'(2 * k1)); else bus.RQ_VALID[1] = 1'b0;
      end
    end
    bus.RQ_VALID = 2'b00;
    chk("run_both_k0", 64'(k0), 64'(n));
    chk("run_both_k1", 64'(k1), 64'(n));
  endtask

  // ---------------- Directed sequence ----------------
  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA5A5_0000 + i;
    bus.RQ_VALID = 2'b00; bus.RQ_WRITE = 2'b00; bus.RQ_ADDR = '0; bus.RQ_WDATA = '0;
    ARESETn = 1'b1;
    #2 ARESETn = 1'b0;
    #1;
    chk("reset_valids", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                         bus.M_AXI_BREADY, bus.M_AXI_RREADY, bus.RQ_READY}, 7'd0);
    chk("reset_rsp", {bus.RSP_VALID, bus.RSP_ERR, bus.RSP_RDATA}, 35'd0);
    chk("reset_latched", {bus.M_AXI_AWADDR, bus.M_AXI_WDATA, bus.M_AXI_AWID}, 39'd0);
    repeat (2) @(posedge ACLK);
    #3 ARESETn = 1'b1;

    // Single write then read-back from the other port.
    rdy0_hi = 0;
    issue(0, 1'b1, 6'h05, 32'h0756_3314);
    wait_done();
    chk("rq_ready0_cycles", 64'(rdy0_hi), 64'd1);
    issue(1, 1'b0, 6'h05, 32'h0);
    wait_done();
    chk("readback_rdata", bus.RSP_RDATA, 32'h0756_3314);

    // Contention: alternating grants starting with requester 0.
    grant_log.delete();
    run_both(4, 1'b1, 1'b1, 6'h10, 6'h11);
    wait_done();
    chk("grant_count", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < grant_log.size(); i++) chk("grant_order", 64'(grant_log[i]), 64'(i % 2));
    issue(0, 1'b0, 6'h17, 32'h0);
    wait_done();

    // Skewed write handshakes.
    aw_dly = 2; aw_hi = 0; w_hi = 0;
    issue(0, 1'b1, 6'h20, 32'hDEAD_BEEF);
    wait_done();
    chk("skew_awvalid_cycles", 64'(aw_hi), 64'd3);
    chk("skew_wvalid_cycles", 64'(w_hi), 64'd1);
    aw_dly = 0;

    // Error responses.
    bresp_k = 2'b10;
    issue(1, 1'b1, 6'h21, 32'h1234_5678);
    wait_done();
    bresp_k = 2'b00;
    rlast_k = 1'b0;
    issue(0, 1'b0, 6'h20, 32'h0);
    wait_done();
    rlast_k = 1'b1;
    rid_flip = 1'b1;
    issue(1, 1'b0, 6'h05, 32'h0);
    wait_done();
    rid_flip = 1'b0;

    // Reset while waiting for read data.
    r_dly = 5;
    issue(1, 1'b0, 6'h10, 32'h0);
    for (int c = 0; c < 50 && !bus.M_AXI_RREADY; c++) @(negedge ACLK);
    chk("rd_resp_reached", bus.M_AXI_RREADY, 1'b1);
    @(posedge ACLK);
    #3 ARESETn = 1'b0;
    #1;
    chk("midrst_valids", {bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.M_AXI_AWVALID,
                          bus.M_AXI_WVALID, bus.M_AXI_BREADY}, 5'd0);
    chk("midrst_rsp", {bus.RSP_VALID, bus.RSP_ERR, bus.RSP_RDATA}, 35'd0);
    chk("midrst_latched", {bus.M_AXI_ARADDR, bus.M_AXI_ARID}, 7'd0);
    sb.delete();
    grant_log.delete();
    last_rd = '0;
    r_dly = 0;
    repeat (2) @(posedge ACLK);
    #3 ARESETn = 1'b1;
    repeat (3) @(posedge ACLK);
    run_both(1, 1'b0, 1'b1, 6'h05, 6'h30);
    wait_done();
    chk("post_rst_first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : 9), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
